// File: rtl/led_pattern_stepper.sv
// led_pattern_stepper: steps a one-hot LED pattern (chase or bounce) on rising edges of a slow tick,
// with single-cycle step/wrap strobes aligned to each LED update.
module led_pattern_stepper #(
    parameter int NUM_LEDS       = 4,
    parameter int EDGES_PER_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                en,
    input  logic                mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step,
    output logic                wrap
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int CW = $clog2(EDGES_PER_STEP + 1);
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] CMAX = CW'(EDGES_PER_STEP - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHASE, S_BOUNCE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d, pos_inc;
    logic                  dir_q, dir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_LEDS-1:0]   leds_q, leds_d;
    logic                  tick_q, step_q, wrap_q, wrap_d;
    logic                  qual_edge, do_step, up;

    assign qual_edge = tick_in & ~tick_q & en;
    assign do_step   = qual_edge && (cnt_q == CMAX);
    assign pos_inc   = pos_q + 1'b1;
    // dir_q is only meaningful inside bounce; arriving from chase always starts upward
    assign up        = (state_q != S_BOUNCE) || !dir_q;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        cnt_d   = qual_edge ? (do_step ? '0 : cnt_q + 1'b1) : cnt_q;
        if (do_step) begin
            if (state_q == S_IDLE) begin
                state_d = mode ? S_BOUNCE : S_CHASE;
                pos_d   = '0;
                dir_d   = 1'b0;
            end else if (!mode) begin
                state_d = S_CHASE;
                pos_d   = (pos_q == LAST) ? '0 : pos_inc;
                wrap_d  = (pos_q == LAST);
            end else if (up) begin
                state_d = S_BOUNCE;
                pos_d   = (pos_q == LAST) ? LAST - 1'b1 : pos_inc;
                dir_d   = (pos_q == LAST) || (pos_inc == LAST);
                wrap_d  = (pos_q != LAST) && (pos_inc == LAST);
            end else begin
                state_d = S_BOUNCE;
                pos_d   = (pos_q == '0) ? pos_inc : pos_q - 1'b1;
                dir_d   = (pos_q > PW'(1));
                wrap_d  = (pos_q == PW'(1));
            end
        end
        leds_d = (state_d == S_IDLE) ? '0 : {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            leds_q  <= '0;
            tick_q  <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            tick_q  <= tick_in;
            step_q  <= do_step;
            wrap_q  <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_led_pattern_stepper.sv
// tb_led_pattern_stepper: directed checks of chase, bounce, prescale, enable gating, reset and mode switch.
module tb_led_pattern_stepper;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       en = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] leds1, leds3;
    logic       step1, step3, wrap1, wrap3;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    led_pattern_stepper #(.NUM_LEDS(4), .EDGES_PER_STEP(1)) u1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .mode(mode),
        .leds(leds1), .step(step1), .wrap(wrap1)
    );
    led_pattern_stepper #(.NUM_LEDS(4), .EDGES_PER_STEP(3)) u3 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .mode(mode),
        .leds(leds3), .step(step3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic m);
        @(negedge clk);
        rst = 1'b1; tick_in = 1'b0; en = 1'b1; mode = m;
        @(posedge clk); #1;
        check("rst_leds1", leds1, 4'b0000);
        check("rst_leds3", leds3, 4'b0000);
        check("rst_step", {step1, step3, wrap1, wrap3}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic rise();
        @(negedge clk);
        tick_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fall();
        @(negedge clk);
        tick_in = 1'b0;
        @(posedge clk); #1;
        check("step_off", {step1, step3, wrap1, wrap3}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic edge1(input string tag, input logic [3:0] exp_leds, input logic exp_wrap);
        rise();
        check({tag, "_leds"}, leds1, exp_leds);
        check({tag, "_step"}, step1, 1'b1);
        check({tag, "_wrap"}, wrap1, exp_wrap);
        fall();
    endtask

    logic [3:0] chase_l [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       chase_w [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] bnc_l   [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       bnc_w   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) edge1($sformatf("chase%0d", i), chase_l[i], chase_w[i]);

        do_reset(1'b1);
        for (int i = 0; i < 8; i++) edge1($sformatf("bounce%0d", i), bnc_l[i], bnc_w[i]);

        do_reset(1'b0);
        for (int i = 1; i <= 9; i++) begin
            rise();
            check($sformatf("pre_step%0d", i), step3, (i % 3 == 0));
            fall();
        end
        check("pre_leds", leds3, 4'b0100);

        do_reset(1'b0);
        edge1("gate_a", 4'b0001, 1'b0);
        edge1("gate_b", 4'b0010, 1'b0);
        @(negedge clk);
        en = 1'b0; tick_in = 1'b1;
        @(posedge clk); #1;
        check("gate_fall_edge", {leds1, step1, step3}, {4'b0010, 2'b00});
        fall();
        rise();
        check("gate_off_edge", {leds1, step1, step3}, {4'b0010, 2'b00});
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("gate_en_high", {leds1, step1, step3}, {4'b0010, 2'b00});
        check("gate_leds3", leds3, 4'b0000);
        fall();
        rise();
        check("gate_resume1", {leds1, step1}, {4'b0100, 1'b1});
        check("gate_resume3", {leds3, step3}, {4'b0001, 1'b1});
        fall();

        do_reset(1'b0);
        edge1("rs_a", 4'b0001, 1'b0);
        edge1("rs_b", 4'b0010, 1'b0);
        rise();
        check("rs_pre", leds1, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rs_leds", {leds1, step1}, {4'b0000, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rs_hold%0d", i), {leds1, step1}, {4'b0000, 1'b0});
        end
        fall();
        edge1("rs_first", 4'b0001, 1'b0);

        do_reset(1'b0);
        for (int i = 0; i < 4; i++) edge1($sformatf("ms_run%0d", i), chase_l[i], 1'b0);
        mode = 1'b1;
        edge1("ms_bounce", 4'b0100, 1'b0);
        mode = 1'b0;
        edge1("ms_chase", 4'b1000, 1'b0);
        edge1("ms_wrap", 4'b0001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
